vdp_cpu_port: RTL and testbench

- CPU-side port of the TMS9918-style VDP. Decodes Z80 I/O accesses to the data port (0x98) and control port (0x99).
- Drives the CPU port of the shared VRAM: address, write data, write strobe, read strobe, read data.
- Holds VDP registers R0-R7 and derives from them the table bases, mode, colours and sprite flags that the video generator consumes.
- Owns the status register and the interrupt line.

---
 rtl/vdp_pkg.sv | 36 +++
 rtl/vdp_regfile.sv | 74 +++++++
 rtl/vdp_cpu_port.sv | 169 ++++++++++++++++
 tb/tb_vdp_cpu_port.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_pkg.sv
// Shared constants and types for the TMS9918-style VDP CPU port.
// Register indices, display modes, status bits and control-byte opcodes.
package vdp_pkg;

    localparam logic [2:0] R0 = 3'd0;
    localparam logic [2:0] R1 = 3'd1;
    localparam logic [2:0] R2 = 3'd2;
    localparam logic [2:0] R3 = 3'd3;
    localparam logic [2:0] R4 = 3'd4;
    localparam logic [2:0] R5 = 3'd5;
    localparam logic [2:0] R6 = 3'd6;
    localparam logic [2:0] R7 = 3'd7;

    typedef enum logic [1:0] {
        MODE_TEXT = 2'd0,
        MODE_G1   = 2'd1,
        MODE_G2   = 2'd2,
        MODE_MC   = 2'd3
    } vdp_mode_t;

    localparam int ST_F  = 7;
    localparam int ST_5S = 6;
    localparam int ST_C  = 5;

    // Second control byte: bit 7 selects a register write,
    // bit 6 selects VRAM write setup (no prefetch) over read setup.
    localparam int CTL_REG   = 7;
    localparam int CTL_WRITE = 6;

    typedef enum logic [1:0] {
        IDLE,
        PREFETCH_ISSUE,
        PREFETCH_LOAD
    } port_state_t;

endpackage

// File: rtl/vdp_regfile.sv
// VDP write-only registers R0-R7 and the video settings derived from them.
// Derivations are combinational from the register flops.
module vdp_regfile
    import vdp_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [2:0]        idx,
    input  logic [7:0]        wdata,
    output logic [1:0]        mode,
    output logic              video_on,
    output logic              int_en,
    output logic              sprite_large,
    output logic              sprite_enlarged,
    output logic [ADDR_W-1:0] name_table_addr,
    output logic [ADDR_W-1:0] color_table_addr,
    output logic [ADDR_W-1:0] font_addr,
    output logic [ADDR_W-1:0] sprite_attr_addr,
    output logic [ADDR_W-1:0] sprite_pattern_table_addr,
    output logic [3:0]        text_color,
    output logic [3:0]        back_color
);

    logic [7:0] regs [NREGS];
    vdp_mode_t  mode_d;
    logic       unused_bits;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (we && (int'(idx) < NREGS)) begin
            regs[idx] <= wdata;
        end
    end

    // M1 (text) outranks M2 (multicolour), which outranks M3 (graphics II).
    always_comb begin
        mode_d = MODE_G1;
        if (regs[R1][4]) begin
            mode_d = MODE_TEXT;
        end else if (regs[R1][3]) begin
            mode_d = MODE_MC;
        end else if (regs[R0][1]) begin
            mode_d = MODE_G2;
        end
    end

    assign mode            = mode_d;
    assign video_on        = regs[R1][6];
    assign int_en          = regs[R1][5];
    assign sprite_large    = regs[R1][1];
    assign sprite_enlarged = regs[R1][0];

    assign name_table_addr           = {regs[R2][3:0], 10'b0};
    assign color_table_addr          = {regs[R3], 6'b0};
    assign font_addr                 = {regs[R4][2:0], 11'b0};
    assign sprite_attr_addr          = {regs[R5][6:0], 7'b0};
    assign sprite_pattern_table_addr = {regs[R6][2:0], 11'b0};

    assign text_color = regs[R7][7:4];
    assign back_color = regs[R7][3:0];

    assign unused_bits = ^{regs[R0][7:2], regs[R0][0],
                           regs[R1][7], regs[R1][2],
                           regs[R2][7:4], regs[R4][7:3],
                           regs[R5][7], regs[R6][7:3]};

endmodule

// File: rtl/vdp_cpu_port.sv
// Z80-facing port of the VDP: data/control decode, VRAM pointer and
// read-ahead buffer, register writes, status register and interrupt.
module vdp_cpu_port
    import vdp_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_cs,
    input  logic              cpu_wr,
    input  logic              cpu_rd,
    input  logic              cpu_a0,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_din,
    output logic              vram_wr,
    output logic              vram_rd,
    input  logic [7:0]        vram_dout,
    input  logic              frame_int,
    input  logic              sprite_collision,
    input  logic              too_many_sprites,
    input  logic [4:0]        sprite5,
    output logic [1:0]        mode,
    output logic              video_on,
    output logic              sprite_large,
    output logic              sprite_enlarged,
    output logic [ADDR_W-1:0] name_table_addr,
    output logic [ADDR_W-1:0] color_table_addr,
    output logic [ADDR_W-1:0] font_addr,
    output logic [ADDR_W-1:0] sprite_attr_addr,
    output logic [ADDR_W-1:0] sprite_pattern_table_addr,
    output logic [3:0]        text_color,
    output logic [3:0]        back_color,
    output logic              n_int
);

    port_state_t       state, state_n;
    logic [ADDR_W-1:0] ptr, ptr_cur;
    logic [7:0]        latch, rbuf, rbuf_cur;
    logic              flag;
    logic              st_f, st_5s, st_c;
    logic [4:0]        spr5;
    logic              int_en;

    logic acc, wr_data, rd_data, wr_ctrl, rd_stat;
    logic ctrl1, ctrl2, reg_we, prefetch_ctrl;

    assign acc     = cpu_cs & (cpu_wr ^ cpu_rd) & ~reset;
    assign wr_data = acc & cpu_wr & ~cpu_a0;
    assign rd_data = acc & cpu_rd & ~cpu_a0;
    assign wr_ctrl = acc & cpu_wr & cpu_a0;
    assign rd_stat = acc & cpu_rd & cpu_a0;

    assign ctrl1         = wr_ctrl & ~flag;
    assign ctrl2         = wr_ctrl & flag;
    assign reg_we        = ctrl2 & cpu_din[CTL_REG];
    assign prefetch_ctrl = ctrl2 & ~cpu_din[CTL_REG] & ~cpu_din[CTL_WRITE];

    // An access landing on the load cycle sees the post-prefetch pointer
    // and the byte arriving from VRAM.
    assign ptr_cur  = (state == PREFETCH_LOAD) ? ptr + ADDR_W'(1) : ptr;
    assign rbuf_cur = (state == PREFETCH_LOAD) ? vram_dout : rbuf;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        vram_rd   = 1'b0;
        vram_wr   = 1'b0;
        vram_addr = ptr_cur;
        vram_din  = cpu_din;
        unique case (state)
            PREFETCH_ISSUE: begin
                vram_rd   = 1'b1;
                vram_addr = ptr;
                state_n   = PREFETCH_LOAD;
            end
            default: begin
                vram_wr = wr_data;
                state_n = (rd_data | prefetch_ctrl) ? PREFETCH_ISSUE : IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            latch    <= 8'h00;
            flag     <= 1'b0;
            rbuf     <= 8'h00;
            cpu_dout <= 8'h00;
            st_f     <= 1'b0;
            st_5s    <= 1'b0;
            st_c     <= 1'b0;
            spr5     <= 5'd0;
        end else begin
            if (state == PREFETCH_LOAD) begin
                rbuf <= vram_dout;
                ptr  <= ptr + ADDR_W'(1);
            end
            if (wr_data) begin
                rbuf <= cpu_din;
                ptr  <= ptr_cur + ADDR_W'(1);
                flag <= 1'b0;
            end
            if (rd_data) begin
                cpu_dout <= rbuf_cur;
                ptr      <= ptr_cur;
                flag     <= 1'b0;
            end
            if (ctrl1) begin
                latch <= cpu_din;
                flag  <= 1'b1;
            end
            if (ctrl2) begin
                flag <= 1'b0;
                if (!cpu_din[CTL_REG]) begin
                    ptr <= {cpu_din[5:0], latch};
                end
            end
            if (rd_stat) begin
                cpu_dout <= {st_f, st_5s, st_c, spr5};
                flag     <= 1'b0;
            end
            // A set source in the read cycle survives the clear.
            st_f <= frame_int | (st_f & ~rd_stat);
            st_c <= sprite_collision | (st_c & ~rd_stat);
            if (too_many_sprites && !st_5s) begin
                st_5s <= 1'b1;
                spr5  <= sprite5;
            end
        end
    end

    assign n_int = ~(st_f & int_en);

    vdp_regfile #(
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk                       (clk),
        .reset                     (reset),
        .we                        (reg_we),
        .idx                       (cpu_din[2:0]),
        .wdata                     (latch),
        .mode                      (mode),
        .video_on                  (video_on),
        .int_en                    (int_en),
        .sprite_large              (sprite_large),
        .sprite_enlarged           (sprite_enlarged),
        .name_table_addr           (name_table_addr),
        .color_table_addr          (color_table_addr),
        .font_addr                 (font_addr),
        .sprite_attr_addr          (sprite_attr_addr),
        .sprite_pattern_table_addr (sprite_pattern_table_addr),
        .text_color                (text_color),
        .back_color                (back_color)
    );

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Scoreboard bench for vdp_cpu_port with a behavioural VRAM model.
// Expected VRAM/CPU events are queued by stimulus and popped by a monitor.
module tb_vdp_cpu_port;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_cs = 1'b0, cpu_wr = 1'b0, cpu_rd = 1'b0, cpu_a0 = 1'b0;
    logic [7:0]  cpu_din = 8'h00;
    logic [7:0]  cpu_dout;
    logic [13:0] vram_addr;
    logic [7:0]  vram_din;
    logic        vram_wr, vram_rd;
    logic [7:0]  vram_dout = 8'h00;
    logic        frame_int = 1'b0, sprite_collision = 1'b0, too_many_sprites = 1'b0;
    logic [4:0]  sprite5 = 5'd0;
    logic [1:0]  mode;
    logic        video_on, sprite_large, sprite_enlarged, n_int;
    logic [13:0] name_table_addr, color_table_addr, font_addr;
    logic [13:0] sprite_attr_addr, sprite_pattern_table_addr;
    logic [3:0]  text_color, back_color;

    int n_checks = 0;
    int n_fail   = 0;

    logic [21:0] exp_wr[$];
    logic [13:0] exp_rd[$];
    logic [7:0]  exp_dout[$];
    logic        dout_pend = 1'b0;
    logic [7:0]  mem [16384];

    always #5 clk = ~clk;

    vdp_cpu_port dut (
        .clk(clk), .reset(reset),
        .cpu_cs(cpu_cs), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_a0(cpu_a0),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .vram_addr(vram_addr), .vram_din(vram_din),
        .vram_wr(vram_wr), .vram_rd(vram_rd), .vram_dout(vram_dout),
        .frame_int(frame_int), .sprite_collision(sprite_collision),
        .too_many_sprites(too_many_sprites), .sprite5(sprite5),
        .mode(mode), .video_on(video_on),
        .sprite_large(sprite_large), .sprite_enlarged(sprite_enlarged),
        .name_table_addr(name_table_addr), .color_table_addr(color_table_addr),
        .font_addr(font_addr), .sprite_attr_addr(sprite_attr_addr),
        .sprite_pattern_table_addr(sprite_pattern_table_addr),
        .text_color(text_color), .back_color(back_color), .n_int(n_int)
    );

    always @(posedge clk) begin
        if (vram_wr) mem[vram_addr] <= vram_din;
        if (vram_rd) vram_dout <= mem[vram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexp(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected event, got %0h expected none", name, act);
    endtask

    // Monitor: compares every DUT output event against the queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (dout_pend) begin
                dout_pend = 1'b0;
                if (exp_dout.size() == 0) unexp("cpu_dout", 32'(cpu_dout));
                else chk("cpu_dout", 32'(cpu_dout), 32'(exp_dout.pop_front()));
            end
            if (vram_wr) begin
                if (exp_wr.size() == 0) unexp("vram_wr", 32'({vram_addr, vram_din}));
                else chk("vram_wr addr/data", 32'({vram_addr, vram_din}),
                         32'(exp_wr.pop_front()));
            end
            if (vram_rd) begin
                if (exp_rd.size() == 0) unexp("vram_rd", 32'(vram_addr));
                else chk("vram_rd addr", 32'(vram_addr), 32'(exp_rd.pop_front()));
            end
            if (cpu_cs && cpu_rd && !cpu_wr) dout_pend = 1'b1;
        end
    end

    task automatic strobe(input logic a0, input logic wr, input logic rd,
                          input logic [7:0] d);
        @(posedge clk); #1;
        cpu_cs = 1'b1; cpu_a0 = a0; cpu_wr = wr; cpu_rd = rd; cpu_din = d;
        @(posedge clk); #1;
        cpu_cs = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic ctrl(input logic [7:0] d);
        strobe(1'b1, 1'b1, 1'b0, d);
    endtask

    task automatic wreg(input logic [2:0] idx, input logic [7:0] v);
        ctrl(v);
        ctrl({5'b10000, idx});
    endtask

    task automatic dwr(input logic [13:0] a, input logic [7:0] d);
        exp_wr.push_back({a, d});
        strobe(1'b0, 1'b1, 1'b0, d);
    endtask

    task automatic drd(input logic [7:0] e, input logic [13:0] pf);
        exp_dout.push_back(e);
        exp_rd.push_back(pf);
        strobe(1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic srd(input logic [7:0] e);
        exp_dout.push_back(e);
        strobe(1'b1, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic pulse_frame();
        @(posedge clk); #1 frame_int = 1'b1;
        @(posedge clk); #1 frame_int = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst cpu_dout", 32'(cpu_dout), 32'h00);
        chk("rst vram_wr", 32'(vram_wr), 32'h0);
        chk("rst vram_rd", 32'(vram_rd), 32'h0);
        chk("rst n_int", 32'(n_int), 32'h1);
        chk("rst mode", 32'(mode), 32'h1);
        chk("rst name", 32'(name_table_addr), 32'h0);
        chk("rst colors", 32'({text_color, back_color}), 32'h00);

        // read buffer is 0 after reset; prefetch at pointer 0
        drd(8'h00, 14'h0000);

        // write setup 0x0700 and two data writes
        ctrl(8'h00);
        ctrl(8'h47);
        dwr(14'h0700, 8'hAA);
        dwr(14'h0701, 8'hBB);
        // buffer holds last written byte, pointer sits at 0x0702
        drd(8'hBB, 14'h0702);

        // R1 = 0x05 then R0 = 0x02
        wreg(3'd1, 8'h05);
        chk("R1=05 enlarged", 32'(sprite_enlarged), 32'h1);
        chk("R1=05 large", 32'(sprite_large), 32'h0);
        chk("R1=05 video_on", 32'(video_on), 32'h0);
        chk("R1=05 mode", 32'(mode), 32'h1);
        wreg(3'd0, 8'h02);
        chk("R0=02 mode", 32'(mode), 32'h2);
        wreg(3'd1, 8'h08);
        chk("R1=08 mode", 32'(mode), 32'h3);
        wreg(3'd1, 8'h18);
        chk("R1=18 mode", 32'(mode), 32'h0);
        wreg(3'd1, 8'h43);
        chk("R1=43 flags", 32'({video_on, sprite_large, sprite_enlarged}), 32'h7);
        chk("R1=43 mode", 32'(mode), 32'h2);

        wreg(3'd2, 8'hF5);
        wreg(3'd3, 8'h81);
        wreg(3'd4, 8'hFA);
        wreg(3'd5, 8'hFF);
        wreg(3'd6, 8'h0D);
        wreg(3'd7, 8'hF4);
        chk("name base", 32'(name_table_addr), 32'h1400);
        chk("color base", 32'(color_table_addr), 32'h2040);
        chk("font base", 32'(font_addr), 32'h1000);
        chk("sprite attr base", 32'(sprite_attr_addr), 32'h3F80);
        chk("sprite pat base", 32'(sprite_pattern_table_addr), 32'h2800);
        chk("text/back color", 32'({text_color, back_color}), 32'hF4);

        // preload 0x1234/0x1235, then read setup with prefetch
        ctrl(8'h34);
        ctrl(8'h52);
        dwr(14'h1234, 8'h5A);
        dwr(14'h1235, 8'h6B);
        ctrl(8'h34);
        exp_rd.push_back(14'h1234);
        ctrl(8'h12);
        drd(8'h5A, 14'h1235);
        drd(8'h6B, 14'h1236);

        // pointer wrap on writes and on prefetch
        ctrl(8'hFF);
        ctrl(8'h7F);
        dwr(14'h3FFF, 8'h11);
        dwr(14'h0000, 8'h22);
        ctrl(8'hFF);
        exp_rd.push_back(14'h3FFF);
        ctrl(8'h3F);
        drd(8'h11, 14'h0000);

        // interrupt enable and F flag
        wreg(3'd1, 8'h20);
        chk("n_int idle", 32'(n_int), 32'h1);
        pulse_frame();
        chk("n_int after frame", 32'(n_int), 32'h0);
        srd(8'h80);
        chk("n_int after status rd", 32'(n_int), 32'h1);
        srd(8'h00);

        // frame_int coincident with status read wins
        exp_dout.push_back(8'h00);
        @(posedge clk); #1;
        cpu_cs = 1'b1; cpu_a0 = 1'b1; cpu_rd = 1'b1; cpu_wr = 1'b0; frame_int = 1'b1;
        @(posedge clk); #1;
        cpu_cs = 1'b0; cpu_rd = 1'b0; frame_int = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("n_int coincident", 32'(n_int), 32'h0);
        srd(8'h80);

        // collision and 5th sprite (sticky capture)
        @(posedge clk); #1 sprite_collision = 1'b1;
        @(posedge clk); #1 sprite_collision = 1'b0;
        srd(8'h20);
        sprite5 = 5'h13;
        @(posedge clk); #1 too_many_sprites = 1'b1;
        @(posedge clk); #1 too_many_sprites = 1'b0;
        srd(8'h53);
        sprite5 = 5'h05;
        @(posedge clk); #1 too_many_sprites = 1'b1;
        @(posedge clk); #1 too_many_sprites = 1'b0;
        srd(8'h53);

        // status read discards a pending first control byte
        ctrl(8'h10);
        srd(8'h53);
        ctrl(8'h34);
        exp_rd.push_back(14'h1234);
        ctrl(8'h12);
        drd(8'h5A, 14'h1235);

        // malformed strobes are ignored
        strobe(1'b0, 1'b1, 1'b1, 8'hEE);
        strobe(1'b0, 1'b0, 1'b0, 8'hEE);
        strobe(1'b1, 1'b1, 1'b1, 8'hEE);
        drd(8'h6B, 14'h1236);

        // reset mid-sequence discards first control byte
        ctrl(8'h10);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("rst2 cpu_dout", 32'(cpu_dout), 32'h00);
        chk("rst2 n_int", 32'(n_int), 32'h1);
        chk("rst2 mode", 32'(mode), 32'h1);
        chk("rst2 name", 32'(name_table_addr), 32'h0);
        srd(8'h00);
        ctrl(8'h34);
        exp_rd.push_back(14'h1234);
        ctrl(8'h12);
        drd(8'h5A, 14'h1235);

        repeat (5) @(posedge clk);
        #1;
        chk("pending vram_wr", 32'(exp_wr.size()), 32'h0);
        chk("pending vram_rd", 32'(exp_rd.size()), 32'h0);
        chk("pending cpu_dout", 32'(exp_dout.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
